// File: rtl/hangman_keys_pkg.sv
// Shared PS/2 set-2 scan-code constants, internal key codes and parser state
// encoding for the Hangman keyboard path.
package hangman_keys_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_ENTER = 8'h0A;
  localparam logic [7:0] KEY_BKSP  = 8'h08;
  localparam logic [7:0] KEY_RIGHT = 8'h12;
  localparam logic [7:0] KEY_LEFT  = 8'h14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } kbd_state_e;

  function automatic logic is_letter_code(input logic [7:0] code);
    return (code >= 8'h41) && (code <= 8'h5A);
  endfunction

endpackage

// File: rtl/scan2ascii.sv
// Combinational translation of a set-2 scan code (plus E0-extended flag) into
// the internal key code; anything unrecognised maps to KEY_NONE.
module scan2ascii
  import hangman_keys_pkg::*;
(
  input  logic [7:0] scan_code,
  input  logic       ext,
  output logic [7:0] code
);

  always_comb begin
    code = KEY_NONE;
    if (ext) begin
      case (scan_code)
        SC_RIGHT: code = KEY_RIGHT;
        SC_LEFT:  code = KEY_LEFT;
        default:  code = KEY_NONE;
      endcase
    end else begin
      case (scan_code)
        8'h1C: code = 8'h41;  // A
        8'h32: code = 8'h42;  // B
        8'h21: code = 8'h43;  // C
        8'h23: code = 8'h44;  // D
        8'h24: code = 8'h45;  // E
        8'h2B: code = 8'h46;  // F
        8'h34: code = 8'h47;  // G
        8'h33: code = 8'h48;  // H
        8'h43: code = 8'h49;  // I
        8'h3B: code = 8'h4A;  // J
        8'h42: code = 8'h4B;  // K
        8'h4B: code = 8'h4C;  // L
        8'h3A: code = 8'h4D;  // M
        8'h31: code = 8'h4E;  // N
        8'h44: code = 8'h4F;  // O
        8'h4D: code = 8'h50;  // P
        8'h15: code = 8'h51;  // Q
        8'h2D: code = 8'h52;  // R
        8'h1B: code = 8'h53;  // S
        8'h2C: code = 8'h54;  // T
        8'h3C: code = 8'h55;  // U
        8'h2A: code = 8'h56;  // V
        8'h1D: code = 8'h57;  // W
        8'h22: code = 8'h58;  // X
        8'h35: code = 8'h59;  // Y
        8'h1A: code = 8'h5A;  // Z
        SC_ENTER: code = KEY_ENTER;
        SC_BKSP:  code = KEY_BKSP;
        default:  code = KEY_NONE;
      endcase
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Parses PS/2 make/break/E0 byte sequences into a press pulse, a held-key level
// and an arrow-driven letter cursor for the Hangman control path.
module key_event_decoder
  import hangman_keys_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_POS        = 9
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] scan_code,
  input  logic       scan_code_ready,
  output logic [7:0] key_held,
  output logic       key_press,
  output logic [7:0] key_ascii,
  output logic       is_letter,
  output logic       is_enter,
  output logic [3:0] cursor
);

  localparam int unsigned   CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    POS_MAX = 4'(MAX_POS);

  kbd_state_e    state_q, state_d;
  logic [CW-1:0] tmo_q, tmo_d;

  logic       ext_sel, make_evt, rel_evt;
  logic [7:0] code;

  logic [7:0] held_q, held_d;
  logic [7:0] ascii_q, ascii_d;
  logic       press_q, press_d;
  logic       letter_q, letter_d;
  logic       enter_q, enter_d;
  logic [3:0] cursor_q, cursor_d;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  // A byte arriving on the timeout edge takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    if (scan_code_ready) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == SC_EXT)      state_d = ST_EXT;
          else if (scan_code == SC_BRK) state_d = ST_BRK;
        end
        ST_EXT:     state_d = (scan_code == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        ST_BRK:     state_d = ST_IDLE;
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TO_LAST) state_d = ST_IDLE;
      else                  tmo_d   = tmo_q + CW'(1);
    end
  end

  always_comb begin
    ext_sel  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    make_evt = 1'b0;
    rel_evt  = 1'b0;
    if (scan_code_ready) begin
      case (state_q)
        ST_IDLE:    make_evt = (scan_code != SC_EXT) && (scan_code != SC_BRK);
        ST_EXT:     make_evt = (scan_code != SC_BRK);
        ST_BRK:     rel_evt  = 1'b1;
        ST_EXT_BRK: rel_evt  = 1'b1;
        default:    make_evt = 1'b0;
      endcase
    end
  end

  scan2ascii u_scan2ascii (
    .scan_code (scan_code),
    .ext       (ext_sel),
    .code      (code)
  );

  always_comb begin
    held_d   = held_q;
    ascii_d  = ascii_q;
    press_d  = 1'b0;
    letter_d = letter_q;
    enter_d  = enter_q;
    cursor_d = cursor_q;
    if (make_evt && (code != KEY_NONE) && (code != held_q)) begin
      held_d   = code;
      ascii_d  = code;
      press_d  = 1'b1;
      letter_d = is_letter_code(code);
      enter_d  = (code == KEY_ENTER);
      if ((code == KEY_RIGHT) && (cursor_q < POS_MAX)) cursor_d = cursor_q + 4'd1;
      if ((code == KEY_LEFT) && (cursor_q != 4'd0))    cursor_d = cursor_q - 4'd1;
    end else if (rel_evt && (code == held_q)) begin
      held_d = KEY_NONE;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      held_q   <= KEY_NONE;
      ascii_q  <= KEY_NONE;
      press_q  <= 1'b0;
      letter_q <= 1'b0;
      enter_q  <= 1'b0;
      cursor_q <= '0;
    end else begin
      held_q   <= held_d;
      ascii_q  <= ascii_d;
      press_q  <= press_d;
      letter_q <= letter_d;
      enter_q  <= enter_d;
      cursor_q <= cursor_d;
    end
  end

  assign key_held  = held_q;
  assign key_press = press_q;
  assign key_ascii = ascii_q;
  assign is_letter = letter_q;
  assign is_enter  = enter_q;
  assign cursor    = cursor_q;

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
Sits between the PS/2 keyboard receiver and the Hangman control FSM / letter loader. Consumes raw set-2 scan-code bytes and parses make, break and E0-extended sequences. Produces a clean one-cycle press event, a level "currently held key" code, and the letter-cursor position driven by the arrow keys. The held code is 0x00 when no key is down, and the control FSM waits on that value.

Parameters:
TIMEOUT_CYCLES, 1000000, clock cycles a prefix state (E0/F0 received) waits for the next byte before abandoning the sequence (20 ms at 50 MHz).
MAX_POS, 9, highest cursor index; cursor range is 0..MAX_POS.

Ports:
clock  in  1  system clock (CLOCK_50 domain).
resetn  in  1  synchronous, active-low reset.
scan_code  in  8  byte from the PS/2 receiver; valid only while scan_code_ready=1.
scan_code_ready  in  1  one-cycle strobe per received byte, same clock domain.
key_held  out  8  translated code of the key currently held; 0x00 when none is held.
key_press  out  1  one-cycle pulse on a new, recognised key press.
key_ascii  out  8  translated code of the most recent press; holds until the next press.
is_letter  out  1  key_ascii is in 0x41..0x5A; updates with key_press.
is_enter  out  1  key_ascii == 0x0A; updates with key_press.
cursor  out  4  letter slot index 0..MAX_POS.

Behaviour:
- Reset values: key_held=0x00, key_press=0, key_ascii=0x00, is_letter=0, is_enter=0, cursor=0, parser state=IDLE, timeout counter=0.
- Translation (combinational):
  - Letters A–Z map to uppercase ASCII 0x41–0x5A (e.g. 1C→0x41 'A', 32→0x42 'B', 1A→0x5A 'Z').
  - 5A Enter→0x0A; 66 Backspace→0x08.
  - E0 74 right arrow→0x12; E0 6B left arrow→0x14.
  - Any other code→0x00 (unrecognised).
- Parser states: IDLE, EXT, BRK, EXT_BRK. Each transition fires only on an edge where scan_code_ready=1.
  - IDLE: E0→EXT; F0→BRK; any other byte is a normal make code, stay IDLE.
  - EXT: F0→EXT_BRK; any other byte is an extended make code→IDLE.
  - BRK: byte is a normal release code→IDLE.
  - EXT_BRK: byte is an extended release code→IDLE.
- Make handling, latency 1 (outputs change on the edge that samples the final byte; key_press is high for exactly the following cycle):
  - If translated code T≠0x00 and T≠key_held: key_held←T, key_ascii←T, update is_letter/is_enter, pulse key_press.
  - If T==key_held (typematic repeat): no pulse, no change.
  - If T==0x00: ignored entirely.
- Release handling: if T==key_held, key_held←0x00. Otherwise no change; no pulse on release.
- New press while another key is held: the new key replaces key_held. The later release of the old key is ignored.
- Cursor updates on the same edge as key_press:
  - 0x12 increments, saturating at MAX_POS.
  - 0x14 decrements, saturating at 0.
  - key_press still pulses when the cursor is saturated.
- Timeout:
  - Counter clears on every scan_code_ready and while in IDLE.
  - In EXT, BRK or EXT_BRK, if the counter reaches TIMEOUT_CYCLES-1 with no byte, the state returns to IDLE. Outputs are unchanged.
  - If a byte arrives on the same edge the timeout would fire, the byte is processed in the current state (byte wins).
- Reset mid-sequence: all outputs and state take reset values on the next edge. A pending F0 is discarded, so a later release byte is parsed as a make code.
- A byte of 0xE0 or 0xF0 received in BRK/EXT_BRK is treated as the release byte, translates to 0x00, and is ignored.

Decomposition:
- Shared package hangman_keys_pkg holds:
  - scan-code constants (SC_EXT=E0, SC_BRK=F0, SC_ENTER=5A, SC_BKSP=66, SC_LEFT=6B, SC_RIGHT=74);
  - internal codes KEY_NONE=0x00, KEY_ENTER=0x0A, KEY_BKSP=0x08, KEY_RIGHT=0x12, KEY_LEFT=0x14;
  - the parser state encoding.
- One sub-module, scan2ascii: purely combinational, inputs scan_code[7:0] and ext, output code[7:0].

Test Plan:
- 1C, F0 1C → key_press one cycle after 1C, key_ascii=0x41, is_letter=1, key_held 0x41 then 0x00 one cycle after the second 1C.
- 1C 1C 1C (typematic), then F0 1C → exactly one key_press pulse, key_held=0x41 throughout, then 0x00.
- Ten sequences of E0 74 / E0 F0 74 from cursor=0 → cursor 1..9 then stays 9, ten key_press pulses, key_ascii=0x12.
- E0 6B at cursor=0 → cursor stays 0, key_press pulses, key_ascii=0x14. 5A → is_enter=1, key_ascii=0x0A.
- E0, then idle TIMEOUT_CYCLES, then 1C → state back to IDLE; 1C decodes as 'A' (0x41), not an extended code. Also drive a byte exactly on the timeout edge and check it is parsed as extended.
- Hold 1C, send F0, assert resetn=0 for one cycle, then send 1C → all outputs reset; the following 1C is a new press (key_press=1, key_held=0x41).
